micro_uart2_apb_seq: RTL and testbench



---
 rtl/micro_uart2_apb_seq_pkg.sv | 38 +++
 rtl/micro_uart2_apb_seq.sv | 172 +++++++++++++++++
 tb/tb_micro_uart2_apb_seq.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_uart2_apb_seq_pkg.sv
// Shared definitions for the micro UART 2 APB sequencer: register map,
// status bit positions and sequencer state types.
package micro_uart2_apb_seq_pkg;

   localparam logic [15:0] UART2_BAUD_DEFAULT = 16'd26;
   localparam logic [3:0]  UART2_DATA_ADDR    = 4'h0;
   localparam logic [3:0]  UART2_BAUD_ADDR    = 4'h4;
   localparam logic [3:0]  UART2_STAT_ADDR    = 4'h8;
   localparam int unsigned UART2_TX_BUSY_BIT  = 0;
   localparam int unsigned UART2_RX_AVAIL_BIT = 1;

   // ST_IDLE is only occupied while reset is held (bus quiet, psel low).
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_BAUD_SETUP,
      ST_BAUD_ACCESS,
      ST_POLL_SETUP,
      ST_POLL_ACCESS,
      ST_TX_SETUP,
      ST_TX_ACCESS,
      ST_RX_SETUP,
      ST_RX_ACCESS
   } seq_state_e;

   typedef enum logic {
      SRV_TX,
      SRV_RX
   } served_e;

   function automatic logic is_access(input seq_state_e s);
      return s inside {ST_BAUD_ACCESS, ST_POLL_ACCESS, ST_TX_ACCESS, ST_RX_ACCESS};
   endfunction

   function automatic logic is_write(input seq_state_e s);
      return s inside {ST_BAUD_SETUP, ST_BAUD_ACCESS, ST_TX_SETUP, ST_TX_ACCESS};
   endfunction

endpackage

// File: rtl/micro_uart2_apb_seq.sv
// APB master that owns the UART 2 slave port: programs the baud divider, then
// polls status and round-robins TX byte writes against RX byte reads.
module micro_uart2_apb_seq
   import micro_uart2_apb_seq_pkg::*;
#(
   parameter logic [15:0] BAUD_DEFAULT = UART2_BAUD_DEFAULT,
   parameter logic [3:0]  DATA_ADDR    = UART2_DATA_ADDR,
   parameter logic [3:0]  BAUD_ADDR    = UART2_BAUD_ADDR,
   parameter logic [3:0]  STAT_ADDR    = UART2_STAT_ADDR,
   parameter int unsigned TX_BUSY_BIT  = UART2_TX_BUSY_BIT,
   parameter int unsigned RX_AVAIL_BIT = UART2_RX_AVAIL_BIT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        apb_psel,
   output logic        apb_penable,
   output logic        apb_pwrite,
   output logic [3:0]  apb_paddr,
   output logic [31:0] apb_pwdata,
   input  logic [31:0] apb_prdata,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [7:0]  tx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [7:0]  rx_data,
   input  logic        cfg_load,
   input  logic [15:0] cfg_baud,
   output logic        init_done
);

   seq_state_e  state_q, state_d;
   served_e     last_q, last_d;
   logic [15:0] baud_q, baud_d;
   logic        baud_pend_q, baud_pend_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        init_done_q, init_done_d;

   logic        stat_busy;
   logic        stat_avail;
   logic        rx_ok;
   logic        tx_ok;
   logic        unused_prdata_hi;

   assign stat_busy        = apb_prdata[TX_BUSY_BIT];
   assign stat_avail       = apb_prdata[RX_AVAIL_BIT];
   assign rx_ok            = stat_avail && !rx_valid_q;
   assign tx_ok            = tx_valid && !stat_busy;
   assign unused_prdata_hi = ^apb_prdata[31:8];

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      baud_d      = baud_q;
      baud_pend_d = baud_pend_q;
      pwdata_d    = pwdata_q;
      rx_valid_d  = rx_valid_q;
      rx_data_d   = rx_data_q;
      init_done_d = init_done_q;
      apb_paddr   = STAT_ADDR;
      tx_ready    = 1'b0;

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            apb_paddr = '0;
            state_d   = ST_BAUD_SETUP;
         end
         ST_BAUD_SETUP: begin
            apb_paddr = BAUD_ADDR;
            state_d   = ST_BAUD_ACCESS;
         end
         ST_BAUD_ACCESS: begin
            apb_paddr   = BAUD_ADDR;
            baud_pend_d = 1'b0;
            init_done_d = 1'b1;
            state_d     = ST_POLL_SETUP;
         end
         ST_POLL_SETUP: begin
            state_d = ST_POLL_ACCESS;
         end
         ST_POLL_ACCESS: begin
            // A pending baud change only goes out while the transmitter is idle.
            if (baud_pend_q && !stat_busy) begin
               state_d = ST_BAUD_SETUP;
            end else if (rx_ok && tx_ok) begin
               state_d = (last_q == SRV_RX) ? ST_TX_SETUP : ST_RX_SETUP;
            end else if (rx_ok) begin
               state_d = ST_RX_SETUP;
            end else if (tx_ok) begin
               state_d = ST_TX_SETUP;
            end else begin
               state_d = ST_POLL_SETUP;
            end
         end
         ST_TX_SETUP: begin
            apb_paddr = DATA_ADDR;
            state_d   = ST_TX_ACCESS;
         end
         ST_TX_ACCESS: begin
            apb_paddr = DATA_ADDR;
            tx_ready  = 1'b1;
            last_d    = SRV_TX;
            state_d   = ST_POLL_SETUP;
         end
         ST_RX_SETUP: begin
            apb_paddr = DATA_ADDR;
            state_d   = ST_RX_ACCESS;
         end
         ST_RX_ACCESS: begin
            apb_paddr  = DATA_ADDR;
            rx_data_d  = apb_prdata[7:0];
            rx_valid_d = 1'b1;
            last_d     = SRV_RX;
            state_d    = ST_POLL_SETUP;
         end
         default: begin
            apb_paddr = '0;
            state_d   = ST_IDLE;
         end
      endcase

      // Write data is latched on entry to SETUP so it holds through ACCESS
      // even if cfg_load or tx_data move in between.
      if (state_d == ST_BAUD_SETUP) begin
         pwdata_d = {16'h0000, baud_q};
      end else if (state_d == ST_TX_SETUP) begin
         pwdata_d = {24'h000000, tx_data};
      end

      if (cfg_load) begin
         baud_d      = cfg_baud;
         baud_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         last_q      <= SRV_RX;
         baud_q      <= BAUD_DEFAULT;
         baud_pend_q <= 1'b1;
         pwdata_q    <= '0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         baud_q      <= baud_d;
         baud_pend_q <= baud_pend_d;
         pwdata_q    <= pwdata_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         init_done_q <= init_done_d;
      end
   end

   assign apb_psel    = (state_q != ST_IDLE);
   assign apb_penable = is_access(state_q);
   assign apb_pwrite  = is_write(state_q);
   assign apb_pwdata  = pwdata_q;
   assign rx_valid    = rx_valid_q;
   assign rx_data     = rx_data_q;
   assign init_done   = init_done_q;

endmodule

// File: tb/tb_micro_uart2_apb_seq.sv
// Bench for micro_uart2_apb_seq: a transaction-level model of the sequencer
// plus a combinational UART slave, with directed scenarios and random traffic.
module tb_micro_uart2_apb_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        apb_psel, apb_penable, apb_pwrite;
   logic [3:0]  apb_paddr;
   logic [31:0] apb_pwdata, apb_prdata;
   logic        tx_valid, tx_ready;
   logic [7:0]  tx_data;
   logic        rx_valid, rx_ready;
   logic [7:0]  rx_data;
   logic        cfg_load;
   logic [15:0] cfg_baud;
   logic        init_done;

   logic [31:0] stat_reg, data_reg;

   always #5 clk = ~clk;

   // UART slave: status at 0x8, data register everywhere else.
   assign apb_prdata = (apb_paddr == 4'h8) ? stat_reg : data_reg;

   micro_uart2_apb_seq #(
      .BAUD_DEFAULT(16'd26)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .apb_psel    (apb_psel),
      .apb_penable (apb_penable),
      .apb_pwrite  (apb_pwrite),
      .apb_paddr   (apb_paddr),
      .apb_pwdata  (apb_pwdata),
      .apb_prdata  (apb_prdata),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_data     (rx_data),
      .cfg_load    (cfg_load),
      .cfg_baud    (cfg_baud),
      .init_done   (init_done)
   );

   localparam int K_NONE = 0;
   localparam int K_BAUD = 1;
   localparam int K_POLL = 2;
   localparam int K_TX   = 3;
   localparam int K_RX   = 4;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: current transaction kind, which half of it, and the user-visible state.
   int          m_kind;
   logic        m_access;
   logic [31:0] m_wdata;
   logic [15:0] m_baud;
   logic        m_pend;
   logic        m_last_tx;
   logic        m_rxv;
   logic [7:0]  m_rxd;
   logic        m_init;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_kind    = K_NONE;
      m_access  = 1'b0;
      m_wdata   = 32'h0;
      m_baud    = 16'd26;
      m_pend    = 1'b1;
      m_last_tx = 1'b0;
      m_rxv     = 1'b0;
      m_rxd     = 8'h00;
      m_init    = 1'b0;
   endtask

   task automatic compare_outputs();
      logic       e_psel, e_wr;
      logic [3:0] e_addr;
      e_psel = (m_kind != K_NONE);
      e_wr   = (m_kind == K_BAUD) || (m_kind == K_TX);
      case (m_kind)
         K_BAUD:     e_addr = 4'h4;
         K_POLL:     e_addr = 4'h8;
         default:    e_addr = 4'h0;
      endcase
      check("psel",     32'(apb_psel),    32'(e_psel));
      check("penable",  32'(apb_penable), 32'(e_psel && m_access));
      check("pwrite",   32'(apb_pwrite),  32'(e_wr));
      check("paddr",    32'(apb_paddr),   32'(e_addr));
      if (e_wr || !e_psel) check("pwdata", apb_pwdata, m_wdata);
      check("tx_ready", 32'(tx_ready),    32'((m_kind == K_TX) && m_access));
      check("rx_valid", 32'(rx_valid),    32'(m_rxv));
      check("rx_data",  32'(rx_data),     32'(m_rxd));
      check("init_done",32'(init_done),   32'(m_init));
   endtask

   // Advance the model across the coming clock edge using the inputs now driven.
   task automatic model_step();
      int   nk;
      logic busy, avail, rx_ok, tx_ok, old_rxv;
      if (reset) begin
         model_reset();
         return;
      end
      old_rxv = m_rxv;
      nk      = m_kind;
      if (old_rxv && rx_ready) m_rxv = 1'b0;
      if (m_kind == K_NONE) begin
         nk       = K_BAUD;
         m_access = 1'b0;
         m_wdata  = {16'h0, m_baud};
      end else if (!m_access) begin
         m_access = 1'b1;
      end else begin
         m_access = 1'b0;
         nk       = K_POLL;
         case (m_kind)
            K_BAUD: begin m_pend = 1'b0; m_init = 1'b1; end
            K_TX:   m_last_tx = 1'b1;
            K_RX:   begin m_rxd = data_reg[7:0]; m_rxv = 1'b1; m_last_tx = 1'b0; end
            default: begin
               busy  = stat_reg[0];
               avail = stat_reg[1];
               rx_ok = avail && !old_rxv;
               tx_ok = tx_valid && !busy;
               if (m_pend && !busy)     nk = K_BAUD;
               else if (rx_ok && tx_ok) nk = m_last_tx ? K_RX : K_TX;
               else if (rx_ok)          nk = K_RX;
               else if (tx_ok)          nk = K_TX;
               else                     nk = K_POLL;
            end
         endcase
         if (nk == K_BAUD) m_wdata = {16'h0, m_baud};
         if (nk == K_TX)   m_wdata = {24'h0, tx_data};
      end
      if (cfg_load) begin
         m_baud = cfg_baud;
         m_pend = 1'b1;
      end
      m_kind = nk;
   endtask

   task automatic run_cycle();
      compare_outputs();
      model_step();
      @(negedge clk);
   endtask

   initial begin
      int          cnt, cnt2, seen, prev_wr, n_ev;
      logic [31:0] r, cap;

      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      rx_ready = 1'b0;
      cfg_load = 1'b0;
      cfg_baud = 16'h0;
      stat_reg = 32'h0;
      data_reg = 32'h0;
      model_reset();
      @(negedge clk);

      check("rst_psel",      32'(apb_psel),   32'd0);
      check("rst_pwdata",    apb_pwdata,      32'd0);
      check("rst_init_done", 32'(init_done),  32'd0);
      repeat (2) run_cycle();
      reset = 1'b0;
      run_cycle();

      // Baud programming after reset, then polling.
      check("c1_psel",      32'(apb_psel),    32'd1);
      check("c1_penable",   32'(apb_penable), 32'd0);
      check("c1_pwrite",    32'(apb_pwrite),  32'd1);
      check("c1_paddr",     32'(apb_paddr),   32'h4);
      check("c1_pwdata",    apb_pwdata,       32'h1A);
      run_cycle();
      check("c2_penable",   32'(apb_penable), 32'd1);
      check("c2_init_done", 32'(init_done),   32'd0);
      run_cycle();
      check("c3_init_done", 32'(init_done),   32'd1);
      check("c3_paddr",     32'(apb_paddr),   32'h8);
      check("c3_pwrite",    32'(apb_pwrite),  32'd0);

      // Single TX byte with idle UART.
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      cnt      = 0;
      for (int i = 0; i < 14; i++) begin
         if (tx_ready) begin
            cnt++;
            check("tx_paddr",   32'(apb_paddr),   32'h0);
            check("tx_pwdata",  apb_pwdata,       32'hA5);
            check("tx_penable", 32'(apb_penable), 32'd1);
            tx_valid = 1'b0;
         end
         run_cycle();
      end
      check("tx_pulse_count", 32'(cnt), 32'd1);

      // Busy + avail: only RX is served, byte is then held without further reads.
      stat_reg = 32'h3;
      data_reg = 32'hDEAD_BE3C;
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      cnt      = 0;
      for (int i = 0; i < 12; i++) begin
         if (tx_ready) cnt++;
         run_cycle();
      end
      check("rx_held_valid", 32'(rx_valid), 32'd1);
      check("rx_held_data",  32'(rx_data),  32'h3C);
      data_reg = 32'h0000_0011;
      cnt2     = 0;
      for (int i = 0; i < 16; i++) begin
         if (tx_ready) cnt++;
         if (apb_psel && apb_penable && !apb_pwrite && apb_paddr == 4'h0) cnt2++;
         run_cycle();
      end
      check("busy_no_tx",     32'(cnt),     32'd0);
      check("held_no_reads",  32'(cnt2),    32'd0);
      check("held_data",      32'(rx_data), 32'h3C);

      // Both sides ready: data accesses alternate.
      stat_reg = 32'h2;
      rx_ready = 1'b1;
      prev_wr  = -1;
      n_ev     = 0;
      for (int i = 0; i < 60; i++) begin
         if (apb_psel && apb_penable && apb_paddr == 4'h0) begin
            if (prev_wr >= 0) check("rr_alternate", 32'(int'(apb_pwrite) != prev_wr), 32'd1);
            prev_wr = int'(apb_pwrite);
            n_ev++;
         end
         if (tx_ready) tx_data = 8'($urandom());
         data_reg = $urandom();
         run_cycle();
      end
      check("rr_enough_events", 32'(n_ev >= 8), 32'd1);

      // Two baud loads while the transmitter is busy: last value wins, one write.
      tx_valid = 1'b0;
      stat_reg = 32'h1;
      cfg_load = 1'b1;
      cfg_baud = 16'h0100;
      run_cycle();
      cfg_baud = 16'h0200;
      run_cycle();
      cfg_load = 1'b0;
      cnt      = 0;
      for (int i = 0; i < 20; i++) begin
         if (apb_psel && apb_penable && apb_pwrite && apb_paddr == 4'h4) cnt++;
         run_cycle();
      end
      check("baud_wait_busy", 32'(cnt), 32'd0);
      stat_reg = 32'h0;
      cap      = 32'h0;
      for (int i = 0; i < 20; i++) begin
         if (apb_psel && apb_penable && apb_pwrite && apb_paddr == 4'h4) begin
            cnt++;
            cap = apb_pwdata;
         end
         run_cycle();
      end
      check("baud_one_write", 32'(cnt), 32'd1);
      check("baud_value",     cap,      32'h200);

      // Random traffic against the model.
      tx_valid = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r        = $urandom();
         stat_reg = {r[31:2], ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0)};
         data_reg = $urandom();
         rx_ready = ($urandom_range(0, 2) != 0);
         cfg_load = ($urandom_range(0, 39) == 0);
         cfg_baud = 16'($urandom());
         if (tx_ready) begin
            tx_valid = ($urandom_range(0, 1) == 1);
            tx_data  = 8'($urandom());
         end else if (!tx_valid) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom());
         end else if (m_kind != K_TX && $urandom_range(0, 31) == 0) begin
            tx_valid = 1'b0;
         end
         run_cycle();
      end

      // Reset in the middle of a TX access.
      cfg_load = 1'b0;
      rx_ready = 1'b1;
      stat_reg = 32'h0;
      if (!tx_valid) tx_data = 8'h77;
      tx_valid = 1'b1;
      seen     = 0;
      for (int i = 0; i < 24 && seen == 0; i++) begin
         if (tx_ready) seen = 1;
         else run_cycle();
      end
      check("reach_tx_access", 32'(seen), 32'd1);
      reset = 1'b1;
      #1;
      check("arst_psel",      32'(apb_psel),    32'd0);
      check("arst_penable",   32'(apb_penable), 32'd0);
      check("arst_pwrite",    32'(apb_pwrite),  32'd0);
      check("arst_paddr",     32'(apb_paddr),   32'd0);
      check("arst_pwdata",    apb_pwdata,       32'd0);
      check("arst_tx_ready",  32'(tx_ready),    32'd0);
      check("arst_rx_valid",  32'(rx_valid),    32'd0);
      check("arst_rx_data",   32'(rx_data),     32'd0);
      check("arst_init_done", 32'(init_done),   32'd0);
      model_reset();
      tx_valid = 1'b0;
      @(negedge clk);
      run_cycle();
      reset = 1'b0;
      run_cycle();
      check("rel_paddr",  32'(apb_paddr),  32'h4);
      check("rel_pwrite", 32'(apb_pwrite), 32'd1);
      check("rel_pwdata", apb_pwdata,      32'h1A);
      repeat (10) run_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
